csi2_pkt_monitor: RTL and testbench
===================================

Name: csi2_pkt_monitor

Overview:
- Packet-level frame/line monitor on the D-PHY RX packet-header outputs, in parallel with the byte-to-pixel stage; observes only, never gates data.
- Tracks FS/FE/long-packet sequencing and counts lines per frame and frames.
- Checks word count and line count against expected values; runs a frame watchdog.
- Produces sticky error flags for debug and system control.

Parameters:
EXP_WC, 16'd2400, expected long-packet word count in bytes (1920 px RAW10).
EXP_LINES, 16'd1080, expected long packets between FS and FE.
TIMEOUT_CYC, 24'd10_000_000, maximum rx_clk_lp_ctrl cycles in a frame before timeout.

Ports:
rx_clk_lp_ctrl  in  1  continuous monitor clock (same domain as packet outputs)
rst_n  in  1  reset
sp_en_i  in  1  short-packet header valid
lp_av_en_i  in  1  long-packet header valid, dt matches reference
dt_i  in  6  packet data type
wc_i  in  16  word count / short-packet data field
clr_i  in  1  synchronous clear of sticky flags and frame_cnt_o
frame_active_o  out  1  high between FS and FE
frame_done_o  out  1  one-cycle pulse on valid FE
line_cnt_o  out  16  lines in current frame
last_lines_o  out  16  line count latched at last FE
frame_cnt_o  out  16  completed frames, wraps
err_wc_o  out  1  sticky: long packet wc != EXP_WC
err_lines_o  out  1  sticky: last_lines != EXP_LINES at FE
err_seq_o  out  1  sticky: protocol sequence violation
timeout_o  out  1  sticky: watchdog expired
err_fnum_o  out  1  sticky: frame-number error (optional feature)

Behaviour:
- Reset is rst_n, asynchronous, active-low; clock is rx_clk_lp_ctrl.
- All outputs are 0 in reset; FSM is in IDLE.
- All outputs are registered and reflect a qualifying input 1 cycle later.
- Short DTs: FS=6'h00, FE=6'h01. Other short DTs are ignored.
- FSM IDLE:
  - FS -> IN_FRAME; line_cnt cleared; watchdog cleared.
  - FE -> err_seq.
  - Long packet -> err_seq; not counted.
- FSM IN_FRAME:
  - Long packet -> line_cnt+1, saturating at 16'hFFFF; wc_i != EXP_WC sets err_wc.
  - FE -> IDLE; frame_done pulse; last_lines<=line_cnt (including a line counted that cycle, if any); frame_cnt+1 (wraps at 16'hFFFF->0); err_lines if mismatch.
  - FS -> err_seq; stay IN_FRAME; line_cnt restarts at 0; frame not counted.
- Simultaneous sp_en_i & lp_av_en_i: set err_seq, drop the long packet, process the short packet normally.
- Watchdog counts cycles while IN_FRAME. When the count reaches TIMEOUT_CYC: timeout set, go to IDLE, no frame_done, line_cnt held.
- frame_active_o = (state==IN_FRAME).
- clr_i clears all sticky flags and frame_cnt; it does not affect FSM, line_cnt or last_lines. If clr_i and a new error occur in the same cycle, the error wins (flag set).
- Reset mid-frame returns to IDLE; the next packet must be FS to start counting.

Optional Feature:
- Macro: CSI2_MON_FNUM_EN.
- Defined:
  - FS latches wc_i as frame number.
  - FE wc_i != latched number -> err_fnum.
  - Nonzero FS number must equal previous nonzero number+1 (16-bit wrap, skipping 0). The first FS after reset/clr_i is exempt.
  - A number of 0 disables the check for that frame.
- Undefined: err_fnum_o tied 0, no number registers; port retained.

Decomposition:
- Package csi2_mon_pkg holds:
  - DT constants FS/FE/LS/LE.
  - FSM state encoding IDLE/IN_FRAME.
  - Counter width 16.
- Sub-module csi2_mon_watchdog: loadable clear/enable cycle counter with TIMEOUT_CYC compare producing an expire pulse. Instantiated once.

Test Plan:
- FS, 1080 long packets wc=2400, FE -> frame_done 1 pulse, last_lines=1080, frame_cnt=1, all errors 0.
- FS, 1079 lines, FE -> err_lines=1, last_lines=1079; then clr_i -> err_lines=0, frame_cnt=0.
- One line wc=2399 in an otherwise good frame -> err_wc=1, line still counted (1080), err_lines=0.
- Long packet in IDLE, then FE in IDLE, then FS,FS -> err_seq=1, line_cnt=0, frame_cnt unchanged.
- FS then no FE for TIMEOUT_CYC (bench override 100) -> timeout=1 at cycle 100, frame_active=0, no frame_done.
- With CSI2_MON_FNUM_EN: FS#1/FE#1, FS#2/FE#3 -> err_fnum=1; FS#5 after FS#2 -> err_fnum=1. Without the macro, same stimulus -> err_fnum=0.

Source files
------------

// File: rtl/csi2_mon_pkg.sv
// csi2_mon_pkg: shared constants for the CSI-2 packet monitor.
// Data types, FSM encoding, counter width and frame-number helper.
package csi2_mon_pkg;

  localparam int CNT_W = 16;

  localparam logic [5:0] DT_FS = 6'h00;
  localparam logic [5:0] DT_FE = 6'h01;
  localparam logic [5:0] DT_LS = 6'h02;
  localparam logic [5:0] DT_LE = 6'h03;

  localparam logic [0:0] ST_IDLE     = 1'b0;
  localparam logic [0:0] ST_IN_FRAME = 1'b1;

  // Frame numbers run 1..FFFF; zero is reserved for "unnumbered".
  function automatic logic [CNT_W-1:0] fnum_inc(
    input logic [CNT_W-1:0] n
  );
    if (n == '1) fnum_inc = 16'h0001;
    else         fnum_inc = n + 16'h0001;
  endfunction

endpackage

// File: rtl/csi2_mon_watchdog.sv
// csi2_mon_watchdog: frame-length cycle counter.
// Clear has priority; expire is asserted on the TIMEOUT_CYC-th counted cycle.
module csi2_mon_watchdog #(
  parameter logic [23:0] TIMEOUT_CYC = 24'd10_000_000
) (
  input  logic rx_clk_lp_ctrl,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expire
);

  logic [23:0] cnt_q;

  assign expire = en && (cnt_q == TIMEOUT_CYC - 24'd1);

  always_ff @(posedge rx_clk_lp_ctrl or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en && !expire) begin
      cnt_q <= cnt_q + 24'd1;
    end
  end

endmodule

// File: rtl/csi2_pkt_monitor.sv
// csi2_pkt_monitor: CSI-2 frame/line sequencing monitor with sticky errors.
// Define CSI2_MON_FNUM_EN to enable frame-number checking.
module csi2_pkt_monitor
  import csi2_mon_pkg::*;
#(
  parameter logic [15:0] EXP_WC      = 16'd2400,
  parameter logic [15:0] EXP_LINES   = 16'd1080,
  parameter logic [23:0] TIMEOUT_CYC = 24'd10_000_000
) (
  input  logic             rx_clk_lp_ctrl,
  input  logic             rst_n,
  input  logic             sp_en_i,
  input  logic             lp_av_en_i,
  input  logic [5:0]       dt_i,
  input  logic [CNT_W-1:0] wc_i,
  input  logic             clr_i,
  output logic             frame_active_o,
  output logic             frame_done_o,
  output logic [CNT_W-1:0] line_cnt_o,
  output logic [CNT_W-1:0] last_lines_o,
  output logic [CNT_W-1:0] frame_cnt_o,
  output logic             err_wc_o,
  output logic             err_lines_o,
  output logic             err_seq_o,
  output logic             timeout_o,
  output logic             err_fnum_o
);

  logic [0:0]       state_q;
  logic [0:0]       state_d;
  logic             in_frame;
  logic             is_fs;
  logic             is_fe;
  logic             lp_hit;
  logic             fe_ok;
  logic             seq_bad;
  logic             wc_bad;
  logic             wd_exp;
  logic             to_hit;
  logic [CNT_W-1:0] line_nxt;

  assign in_frame = (state_q == ST_IN_FRAME);
  assign is_fs    = sp_en_i && (dt_i == DT_FS);
  assign is_fe    = sp_en_i && (dt_i == DT_FE);
  // A long header colliding with a short one is dropped.
  assign lp_hit   = lp_av_en_i && !sp_en_i;
  assign fe_ok    = in_frame && is_fe;
  assign wc_bad   = in_frame && lp_hit
                 && (wc_i != EXP_WC);
  assign to_hit   = wd_exp && !is_fe && !is_fs;

  assign seq_bad = (sp_en_i && lp_av_en_i)
                || (!in_frame && (is_fe || lp_hit))
                || (in_frame && is_fs);

  always_comb begin
    line_nxt = line_cnt_o;
    if (in_frame && lp_hit && (line_cnt_o != '1))
      line_nxt = line_cnt_o + 16'd1;
  end

  always_comb begin
    state_d = state_q;
    unique case (1'b1)
      is_fs:           state_d = ST_IN_FRAME;
      fe_ok || to_hit: state_d = ST_IDLE;
      default:         state_d = state_q;
    endcase
  end

  csi2_mon_watchdog #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_wd (
    .rx_clk_lp_ctrl (rx_clk_lp_ctrl),
    .rst_n          (rst_n),
    .clr            (is_fs),
    .en             (in_frame),
    .expire         (wd_exp)
  );

  always_ff @(posedge rx_clk_lp_ctrl or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      frame_done_o <= 1'b0;
      line_cnt_o   <= '0;
      last_lines_o <= '0;
    end else begin
      state_q      <= state_d;
      frame_done_o <= fe_ok;
      if (is_fs) line_cnt_o <= '0;
      else       line_cnt_o <= line_nxt;
      if (fe_ok) last_lines_o <= line_nxt;
    end
  end

  assign frame_active_o = in_frame;

  // Sticky flags: a new error in a clear cycle still sets the flag.
  always_ff @(posedge rx_clk_lp_ctrl or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt_o <= '0;
      err_wc_o    <= 1'b0;
      err_lines_o <= 1'b0;
      err_seq_o   <= 1'b0;
      timeout_o   <= 1'b0;
    end else begin
      if (clr_i)
        frame_cnt_o <= {15'd0, fe_ok};
      else if (fe_ok)
        frame_cnt_o <= frame_cnt_o + 16'd1;
      err_wc_o    <= wc_bad  || (err_wc_o && !clr_i);
      err_lines_o <= (fe_ok && (line_nxt != EXP_LINES))
                  || (err_lines_o && !clr_i);
      err_seq_o   <= seq_bad || (err_seq_o && !clr_i);
      timeout_o   <= to_hit  || (timeout_o && !clr_i);
    end
  end

`ifdef CSI2_MON_FNUM_EN
  logic [CNT_W-1:0] fnum_cur_q;
  logic [CNT_W-1:0] fnum_prev_q;
  logic             prev_vld_q;
  logic             err_fnum_q;
  logic             fs_bad;
  logic             fe_bad;

  assign fs_bad = is_fs && (wc_i != '0) && prev_vld_q
               && (wc_i != fnum_inc(fnum_prev_q));
  assign fe_bad = fe_ok && (fnum_cur_q != '0)
               && (wc_i != fnum_cur_q);

  always_ff @(posedge rx_clk_lp_ctrl or negedge rst_n) begin
    if (!rst_n) begin
      fnum_cur_q  <= '0;
      fnum_prev_q <= '0;
      prev_vld_q  <= 1'b0;
      err_fnum_q  <= 1'b0;
    end else begin
      if (is_fs) fnum_cur_q <= wc_i;
      if (is_fs && (wc_i != '0)) begin
        fnum_prev_q <= wc_i;
        prev_vld_q  <= 1'b1;
      end else if (clr_i) begin
        prev_vld_q  <= 1'b0;
      end
      err_fnum_q <= fs_bad || fe_bad
                 || (err_fnum_q && !clr_i);
    end
  end

  assign err_fnum_o = err_fnum_q;
`else
  assign err_fnum_o = 1'b0;
`endif

endmodule

// File: tb/tb_csi2_pkt_monitor.sv
// tb_csi2_pkt_monitor: directed scoreboard bench for csi2_pkt_monitor.
// A second instance with a short watchdog covers the timeout path.
module tb_csi2_pkt_monitor;

  localparam logic [5:0] FS = 6'h00;
  localparam logic [5:0] FE = 6'h01;
  localparam logic [5:0] RAW10 = 6'h2B;
`ifdef CSI2_MON_FNUM_EN
  localparam logic FN = 1'b1;
`else
  localparam logic FN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  logic sp_en, lp_en, clr;
  logic [5:0] dt;
  logic [15:0] wc;
  logic probe_req = 1'b0;

  logic act, done, ewc, eln, esq, eto, efn;
  logic [15:0] line, last, fcnt;
  logic t_act, t_done, t_ewc, t_eln, t_esq, t_eto, t_efn;
  logic [15:0] t_line, t_last, t_fcnt;

  int total = 0;
  int bad = 0;
  int to_done_cnt = 0;

  always #5 clk = ~clk;

  csi2_pkt_monitor #(
    .EXP_WC (16'd2400), .EXP_LINES (16'd1080),
    .TIMEOUT_CYC (24'd5000)
  ) dut (
    .rx_clk_lp_ctrl (clk), .rst_n (rst_n),
    .sp_en_i (sp_en), .lp_av_en_i (lp_en),
    .dt_i (dt), .wc_i (wc), .clr_i (clr),
    .frame_active_o (act), .frame_done_o (done),
    .line_cnt_o (line), .last_lines_o (last),
    .frame_cnt_o (fcnt), .err_wc_o (ewc),
    .err_lines_o (eln), .err_seq_o (esq),
    .timeout_o (eto), .err_fnum_o (efn)
  );

  csi2_pkt_monitor #(
    .EXP_WC (16'd2400), .EXP_LINES (16'd1080),
    .TIMEOUT_CYC (24'd100)
  ) dut_to (
    .rx_clk_lp_ctrl (clk), .rst_n (rst_n),
    .sp_en_i (sp_en), .lp_av_en_i (lp_en),
    .dt_i (dt), .wc_i (wc), .clr_i (clr),
    .frame_active_o (t_act), .frame_done_o (t_done),
    .line_cnt_o (t_line), .last_lines_o (t_last),
    .frame_cnt_o (t_fcnt), .err_wc_o (t_ewc),
    .err_lines_o (t_eln), .err_seq_o (t_esq),
    .timeout_o (t_eto), .err_fnum_o (t_efn)
  );

  typedef struct {
    bit          probe;
    logic [15:0] line;
    logic [15:0] last;
    logic [15:0] fcnt;
    logic        act;
    logic        ewc;
    logic        eln;
    logic        esq;
    logic        eto;
    logic        efn;
  } exp_t;

  exp_t q[$];
  int rec = 0;

  function automatic void chk(string nm, int a, int e);
    total++;
    if (a != e) begin
      bad++;
      $display("FAIL %s rec%0d: got %0d want %0d",
               nm, rec, a, e);
    end
  endfunction

  function automatic void push(bit p, int ln, int ls,
      int fc, logic a, logic w, logic l, logic s,
      logic t, logic f);
    exp_t e;
    e.probe = p; e.line = 16'(ln); e.last = 16'(ls);
    e.fcnt = 16'(fc); e.act = a; e.ewc = w;
    e.eln = l; e.esq = s; e.eto = t; e.efn = f;
    q.push_back(e);
  endfunction

  function automatic void take(bit is_probe);
    exp_t e;
    rec++;
    total++;
    if (q.size() == 0) begin
      bad++;
      $display("FAIL empty rec%0d: got output want none",
               rec);
      return;
    end
    bad = bad;
    e = q.pop_front();
    chk("kind", int'(is_probe), int'(e.probe));
    chk("line_cnt", int'(line), int'(e.line));
    chk("last_lines", int'(last), int'(e.last));
    chk("frame_cnt", int'(fcnt), int'(e.fcnt));
    chk("frame_active", int'(act), int'(e.act));
    chk("err_wc", int'(ewc), int'(e.ewc));
    chk("err_lines", int'(eln), int'(e.eln));
    chk("err_seq", int'(esq), int'(e.esq));
    chk("timeout", int'(eto), int'(e.eto));
    chk("err_fnum", int'(efn), int'(e.efn));
  endfunction

  // Monitor: pops on every frame_done pulse and every probe strobe.
  always @(negedge clk) begin
    if (done) take(1'b0);
    if (probe_req) take(1'b1);
    if (t_done) to_done_cnt++;
  end

  task automatic cyc(input logic s, input logic l,
      input logic [5:0] d, input logic [15:0] w,
      input logic c);
    sp_en = s; lp_en = l; dt = d; wc = w; clr = c;
    @(posedge clk); #1;
    sp_en = 1'b0; lp_en = 1'b0; clr = 1'b0;
  endtask

  task automatic idle();  cyc(0, 0, RAW10, 0, 0); endtask
  task automatic do_clr(); cyc(0, 0, RAW10, 0, 1); endtask
  task automatic fs(input int n);
    cyc(1, 0, FS, 16'(n), 0);
  endtask
  task automatic fe(input int n);
    cyc(1, 0, FE, 16'(n), 0);
  endtask
  task automatic lines(input int n, input int w);
    repeat (n) cyc(0, 1, RAW10, 16'(w), 0);
  endtask

  task automatic probe(int ln, int ls, int fc, logic a,
      logic w, logic l, logic s, logic t, logic f);
    push(1, ln, ls, fc, a, w, l, s, t, f);
    probe_req = 1'b1;
    idle();
    probe_req = 1'b0;
  endtask

  initial begin
    int n;
    rst_n = 1'b0; sp_en = 1'b0; lp_en = 1'b0;
    clr = 1'b0; dt = RAW10; wc = '0;
    repeat (2) @(posedge clk);
    #1;
    probe(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Good frame
    fs(1);
    probe(0, 0, 0, 1, 0, 0, 0, 0, 0);
    lines(540, 2400);
    probe(540, 0, 0, 1, 0, 0, 0, 0, 0);
    lines(540, 2400);
    push(0, 1080, 1080, 1, 0, 0, 0, 0, 0, 0);
    fe(1);
    probe(1080, 1080, 1, 0, 0, 0, 0, 0, 0);

    // Short frame, then clear
    fs(2);
    lines(1079, 2400);
    push(0, 1079, 1079, 2, 0, 0, 1, 0, 0, 0);
    fe(2);
    do_clr();
    probe(1079, 1079, 0, 0, 0, 0, 0, 0, 0);

    // One bad word count
    fs(0);
    lines(500, 2400);
    lines(1, 2399);
    lines(579, 2400);
    push(0, 1080, 1080, 1, 0, 1, 0, 0, 0, 0);
    fe(0);
    do_clr();

    // Sequence errors
    lines(1, 2400);
    probe(1080, 1080, 0, 0, 0, 0, 1, 0, 0);
    cyc(1, 0, FE, 0, 1);
    probe(1080, 1080, 0, 0, 0, 0, 1, 0, 0);
    fs(0);
    lines(2, 2400);
    fs(0);
    probe(0, 1080, 0, 1, 0, 0, 1, 0, 0);
    do_clr();
    probe(0, 1080, 0, 1, 0, 0, 0, 0, 0);
    lines(3, 2400);
    push(0, 3, 3, 1, 0, 0, 1, 1, 0, 0);
    cyc(1, 1, FE, 0, 0);

    // Frame numbers
    do_clr();
    fs(1);
    push(0, 0, 0, 1, 0, 0, 1, 0, 0, 0);
    fe(1);
    fs(2);
    push(0, 0, 0, 2, 0, 0, 1, 0, 0, FN);
    fe(3);
    do_clr();
    fs(2);
    push(0, 0, 0, 1, 0, 0, 1, 0, 0, 0);
    fe(2);
    fs(5);
    push(0, 0, 0, 2, 0, 0, 1, 0, 0, FN);
    fe(5);

    // Watchdog on the short-timeout instance
    do_clr();
    to_done_cnt = 0;
    fs(0);
    rec++;
    chk("to_active_start", int'(t_act), 1);
    chk("to_timeout_start", int'(t_eto), 0);
    n = 0;
    while (t_act && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    chk("to_cycles", n, 100);
    chk("to_timeout", int'(t_eto), 1);
    chk("to_active_end", int'(t_act), 0);
    chk("to_frame_done", to_done_cnt, 0);
    chk("to_line_cnt", int'(t_line), 0);
    probe(0, 0, 0, 1, 0, 0, 0, 0, 0);

    repeat (3) idle();
    chk("queue_left", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1);
  end

endmodule
